// File: rtl/uart_tx_serializer.sv
// UART 8N1 transmitter: byte in on valid/ready, start + 8 data bits LSB first + stop out on o_serial_tx.
// Latency: line drops the cycle after the accept edge; the frame lasts 10*CPB cycles (11*CPB with parity).
// Backpressure: ready is high only in IDLE; valid while not ready is ignored. Optional even parity: UART_TX_PARITY_EN.
module uart_tx_serializer #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_data_in,
   input  logic       i_data_in_valid,
   output logic       o_data_in_ready,
   output logic       o_serial_tx,
   output logic       o_busy
);

   localparam int CPB   = CLOCK_FREQ / BAUD_RATE;
   localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);

   // Bit timing needs at least two clocks per bit
   generate
      if (CPB < 2) begin : g_cpb_check
         $error("uart_tx_serializer: CLOCK_FREQ/BAUD_RATE must be >= 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cycle_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             tx;
`ifdef UART_TX_PARITY_EN
   logic             parity_bit;
`endif

   // Frame sequencer: every line value is registered and held CPB cycles
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state     <= IDLE;
         tx        <= 1'b1;
         cycle_cnt <= '0;
         bit_idx   <= 3'd0;
         shreg     <= 8'd0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_data_in_valid) begin
                  shreg     <= i_data_in;
                  state     <= START;
                  tx        <= 1'b0;
                  cycle_cnt <= '0;
                  bit_idx   <= 3'd0;
`ifdef UART_TX_PARITY_EN
                  parity_bit <= ^i_data_in;
`endif
               end
            end
            START: begin
               if (cycle_cnt == CNT_LAST) begin
                  // Present bit 0 and pre-shift so shreg[0] is always the next bit
                  state     <= DATA;
                  tx        <= shreg[0];
                  shreg     <= {1'b0, shreg[7:1]};
                  cycle_cnt <= '0;
                  bit_idx   <= 3'd0;
               end else begin
                  cycle_cnt <= cycle_cnt + 1'b1;
               end
            end
            DATA: begin
               if (cycle_cnt == CNT_LAST) begin
                  cycle_cnt <= '0;
                  if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= PARITY;
                     tx    <= parity_bit;
`else
                     state <= STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shreg[0];
                     shreg   <= {1'b0, shreg[7:1]};
                  end
               end else begin
                  cycle_cnt <= cycle_cnt + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (cycle_cnt == CNT_LAST) begin
                  state     <= STOP;
                  tx        <= 1'b1;
                  cycle_cnt <= '0;
               end else begin
                  cycle_cnt <= cycle_cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (cycle_cnt == CNT_LAST) begin
                  state     <= IDLE;
                  cycle_cnt <= '0;
               end else begin
                  cycle_cnt <= cycle_cnt + 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               tx        <= 1'b1;
               cycle_cnt <= '0;
            end
         endcase
      end
   end

   assign o_data_in_ready = (state == IDLE);
   assign o_busy          = (state != IDLE);
   assign o_serial_tx     = tx;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer with CPB=10: directed bytes, expected bytes queued at issue,
// a line monitor decodes frames and checks them against the queue.
// Define UART_TX_PARITY_EN for both files to exercise the parity build.
module tb_uart_tx_serializer;

   localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data;
   logic       valid;
   logic       ready;
   logic       tx;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0] exp_q[$];
   int         start_cyc[$];

   uart_tx_serializer #(
      .CLOCK_FREQ(1_000_000),
      .BAUD_RATE (100_000)
   ) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_data_in      (data),
      .i_data_in_valid(valid),
      .o_data_in_ready(ready),
      .o_serial_tx    (tx),
      .o_busy         (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Decode one frame whose start bit was seen at the current negedge
   task automatic collect_frame();
      logic [10:0] bits;
      logic        first;
      logic        stable;
      logic [7:0]  e;
      bits   = '0;
      first  = 1'b0;
      stable = 1'b1;
      for (int b = 0; b < NB; b++) begin
         for (int j = 0; j < CPB; j++) begin
            if (!(b == 0 && j == 0)) @(negedge clk);
            if (!rst_n) return;
            if (j == 0) first = tx;
            else if (tx !== first) stable = 1'b0;
         end
         bits[b] = first;
      end
      if (exp_q.size() == 0) begin
         chk("unexpected_frame", int'(bits[8:1]), -1);
      end else begin
         e = exp_q.pop_front();
         chk("frame_data", int'(bits[8:1]), int'(e));
         chk("stop_bit", int'(bits[NB-1]), 1);
         chk("bit_duration_stable", int'(stable), 1);
`ifdef UART_TX_PARITY_EN
         chk("parity_bit", int'(bits[9]), int'(^e));
`endif
      end
   endtask

   // Line monitor: hunt for a falling edge out of idle, then decode
   initial begin : monitor
      logic prev;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && prev && tx === 1'b0) begin
            start_cyc.push_back(cyc);
            collect_frame();
            prev = 1'b1;
         end else begin
            prev = (tx !== 1'b0);
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      @(negedge clk);
      while (ready !== 1'b1 && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (t >= 500) chk("send_ready_timeout", 0, 1);
      data  = b;
      valid = 1'b1;
      exp_q.push_back(b);
      @(posedge clk);
      #1 valid = 1'b0;
   endtask

   // Counts negedges with ready low, stops on the first with ready high
   task automatic count_ready_low(output int n);
      n = 0;
      forever begin
         @(negedge clk);
         if (ready === 1'b1 || n > 500) break;
         n++;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_queue_empty", exp_q.size(), 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      rst_n = 1'b0;
      valid = 1'b0;
      data  = 8'h00;

      // Reset
      repeat (3) @(posedge clk);
      #1;
      chk("reset_tx", int'(tx), 1);
      chk("reset_ready", int'(ready), 1);
      chk("reset_busy", int'(busy), 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset_ready", int'(ready), 1);
      chk("post_reset_tx", int'(tx), 1);

      // Single byte, single-cycle valid pulse
      send(8'hA5);
      chk("busy_after_accept", int'(busy), 1);
      count_ready_low(n);
      chk("a5_ready_low_cycles", n, FRAME);
      drain();

      // Back-to-back with valid held high
      start_cyc.delete();
      @(negedge clk);
      data  = 8'h00;
      valid = 1'b1;
      exp_q.push_back(8'h00);
      @(posedge clk);
      #1 data = 8'hFF;
      exp_q.push_back(8'hFF);
      count_ready_low(n);
      chk("b2b_first_ready_low", n, FRAME);
      @(posedge clk);
      #1 valid = 1'b0;
      @(negedge clk);
      chk("b2b_second_accepted", int'(ready), 0);
      drain();
      chk("b2b_start_count", start_cyc.size(), 2);
      if (start_cyc.size() == 2)
         chk("b2b_start_spacing", start_cyc[1] - start_cyc[0], FRAME + 1);

      // Drop while busy
      send(8'h3C);
      repeat (39) @(posedge clk);
      @(negedge clk);
      chk("drop_ready_low", int'(ready), 0);
      data  = 8'h99;
      valid = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      count_ready_low(n);
      drain();
      repeat (20) @(negedge clk);
      chk("drop_idle_tx", int'(tx), 1);
      chk("drop_idle_busy", int'(busy), 0);

      // Reset mid-frame
      send(8'h55);
      void'(exp_q.pop_back());
      repeat (34) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midreset_tx", int'(tx), 1);
      rst_n = 1'b1;
      @(negedge clk);
      chk("midreset_ready", int'(ready), 1);
      chk("midreset_busy", int'(busy), 0);
      send(8'h12);
      drain();

      // Input changes after accept do not affect the frame
      send(8'h81);
      repeat (30) @(posedge clk);
      #1 data = 8'h7E;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
